sha_job_arbiter: RTL and testbench

- Shares the single SHAKE engine (FIFO-read / Keccak / FIFO-write chain) between N_REQ hardware requesters, e.g. expand-A, sample-s, challenge and hash-message units.
- Round-robin arbitration over job descriptors; drives the engine's start, mode and length configuration; waits for completion; returns a per-requester ack.
- Exports a one-hot grant used by the top level to steer the engine's read/write AXI-stream ports.
- Includes a watchdog so a stalled job cannot lock out the other requesters.

---
 rtl/sha_job_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_sha_job_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha_job_arbiter.sv
// Round-robin arbiter sharing one SHAKE engine between N_REQ requesters.
// Latches the winner's job descriptor, starts the engine, waits for done or watchdog expiry, then acks.
//
// state   | meaning
// IDLE    | no owner; pick the next requester round-robin from ptr unless hold
// START   | one-cycle SHA3_start pulse to the engine
// GUARD   | ignore SHA3_done (stale level from last job); arm watchdog
// RUN     | wait for SHA3_done or watchdog terminal count
// DONE    | ack (and err on timeout) to the owner; grant still held
// RELEASE | grant dropped; ptr moved past the owner
module sha_job_arbiter #(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 65535,
  parameter int CW          = 16
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic [N_REQ-1:0]      req,
  input  logic [2*N_REQ-1:0]    req_mode,
  input  logic [N_REQ-1:0]      req_sample_sel,
  input  logic [N_REQ-1:0]      req_eta,
  input  logic [32*N_REQ-1:0]   req_byte_read,
  input  logic [10*N_REQ-1:0]   req_byte_write,
  input  logic                  hold,
  output logic [N_REQ-1:0]      ack,
  output logic [N_REQ-1:0]      err,
  output logic [N_REQ-1:0]      grant,
  output logic                  busy,
  output logic                  SHA3_start,
  output logic [1:0]            mode,
  output logic                  sample_sel,
  output logic                  eta,
  output logic [31:0]           byte_read,
  output logic [9:0]            byte_write,
  input  logic                  SHA3_done
);

  localparam int PW = (N_REQ < 2) ? 1 : $clog2(N_REQ);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_GUARD, S_RUN, S_DONE, S_RELEASE
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     gidx_q, gidx_d;
  logic [CW-1:0]     wd_q, wd_d;
  logic              tflag_q, tflag_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [N_REQ-1:0]  ack_q, ack_d;
  logic [N_REQ-1:0]  err_q, err_d;
  logic              busy_q, busy_d;
  logic              start_q, start_d;
  logic [1:0]        mode_q, mode_d;
  logic              ssel_q, ssel_d;
  logic              eta_q, eta_d;
  logic [31:0]       br_q, br_d;
  logic [9:0]        bw_q, bw_d;

  logic              found;
  logic [PW-1:0]     sel;
  int                cand;
  logic [PW-1:0]     cand_idx;

  // First requesting index at or after ptr, wrapping.
  always_comb begin
    found    = 1'b0;
    sel      = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand     = (int'(ptr_q) + k) % N_REQ;
      cand_idx = PW'(cand);
      if (!found && req[cand_idx]) begin
        found = 1'b1;
        sel   = cand_idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    wd_d    = wd_q;
    tflag_d = tflag_q;
    grant_d = grant_q;
    ack_d   = '0;
    err_d   = '0;
    mode_d  = mode_q;
    ssel_d  = ssel_q;
    eta_d   = eta_q;
    br_d    = br_q;
    bw_d    = bw_q;
    case (state_q)
      S_IDLE: begin
        if (!hold && found) begin
          state_d = S_START;
          gidx_d  = sel;
          grant_d = N_REQ'(1) << sel;
          for (int i = 0; i < N_REQ; i++) begin
            if (sel == PW'(i)) begin
              mode_d = req_mode[2*i +: 2];
              ssel_d = req_sample_sel[i];
              eta_d  = req_eta[i];
              br_d   = req_byte_read[32*i +: 32];
              bw_d   = req_byte_write[10*i +: 10];
            end
          end
        end
      end
      S_START: state_d = S_GUARD;
      S_GUARD: begin
        wd_d    = CW'(TIMEOUT_CYC);
        tflag_d = 1'b0;
        state_d = S_RUN;
      end
      S_RUN: begin
        // A done arriving on the terminal-count cycle still counts as a clean finish.
        if (SHA3_done) begin
          state_d = S_DONE;
          tflag_d = 1'b0;
          ack_d   = grant_q;
        end else if (TIMEOUT_CYC != 0 && wd_q == CW'(1)) begin
          state_d = S_DONE;
          tflag_d = 1'b1;
          ack_d   = grant_q;
          err_d   = grant_q;
        end else begin
          wd_d = wd_q - CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_RELEASE;
        grant_d = '0;
        ptr_d   = (gidx_q == PW'(N_REQ - 1)) ? '0 : gidx_q + PW'(1);
      end
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    busy_d  = (state_d != S_IDLE);
    start_d = (state_d == S_START);
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      wd_q    <= '0;
      tflag_q <= 1'b0;
      grant_q <= '0;
      ack_q   <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      mode_q  <= '0;
      ssel_q  <= 1'b0;
      eta_q   <= 1'b0;
      br_q    <= '0;
      bw_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      wd_q    <= wd_d;
      tflag_q <= tflag_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      start_q <= start_d;
      mode_q  <= mode_d;
      ssel_q  <= ssel_d;
      eta_q   <= eta_d;
      br_q    <= br_d;
      bw_q    <= bw_d;
    end
  end

  assign ack        = ack_q;
  assign err        = err_q;
  assign grant      = grant_q;
  assign busy       = busy_q;
  assign SHA3_start = start_q;
  assign mode       = mode_q;
  assign sample_sel = ssel_q;
  assign eta        = eta_q;
  assign byte_read  = br_q;
  assign byte_write = bw_q;

endmodule

// File: tb/tb_sha_job_arbiter.sv
// Bench for sha_job_arbiter: two instances (watchdog 24 and 8) share stimulus,
// a job-timeline model predicts every output each cycle, plus directed literal checks.
module tb_sha_job_arbiter;

  localparam int N = 4;
  localparam int TO0 = 24;
  localparam int TO1 = 8;

  logic clk = 1'b0;
  logic aresetn, hold, SHA3_done;
  logic [N-1:0] req, req_sample_sel, req_eta;
  logic [2*N-1:0] req_mode;
  logic [32*N-1:0] req_byte_read;
  logic [10*N-1:0] req_byte_write;

  logic [N-1:0] ack_o [2];
  logic [N-1:0] err_o [2];
  logic [N-1:0] grant_o [2];
  logic         busy_o [2];
  logic         start_o [2];
  logic [1:0]   mode_o [2];
  logic         ssel_o [2];
  logic         eta_o [2];
  logic [31:0]  br_o [2];
  logic [9:0]   bw_o [2];

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  sha_job_arbiter #(.N_REQ(N), .TIMEOUT_CYC(TO0), .CW(16)) dut0 (
    .clk(clk), .aresetn(aresetn), .req(req), .req_mode(req_mode),
    .req_sample_sel(req_sample_sel), .req_eta(req_eta),
    .req_byte_read(req_byte_read), .req_byte_write(req_byte_write), .hold(hold),
    .ack(ack_o[0]), .err(err_o[0]), .grant(grant_o[0]), .busy(busy_o[0]),
    .SHA3_start(start_o[0]), .mode(mode_o[0]), .sample_sel(ssel_o[0]), .eta(eta_o[0]),
    .byte_read(br_o[0]), .byte_write(bw_o[0]), .SHA3_done(SHA3_done));

  sha_job_arbiter #(.N_REQ(N), .TIMEOUT_CYC(TO1), .CW(16)) dut1 (
    .clk(clk), .aresetn(aresetn), .req(req), .req_mode(req_mode),
    .req_sample_sel(req_sample_sel), .req_eta(req_eta),
    .req_byte_read(req_byte_read), .req_byte_write(req_byte_write), .hold(hold),
    .ack(ack_o[1]), .err(err_o[1]), .grant(grant_o[1]), .busy(busy_o[1]),
    .SHA3_start(start_o[1]), .mode(mode_o[1]), .sample_sel(ssel_o[1]), .eta(eta_o[1]),
    .byte_read(br_o[1]), .byte_write(bw_o[1]), .SHA3_done(SHA3_done));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: each job walks a fixed timeline of phases; stage 0 is no job.
  // 1 = start pulse, 2 = guard, 3 = running, 4 = ack cycle, 5 = release.
  int m_st [2], m_own [2], m_ptr [2], m_run [2];
  bit m_tf [2];
  logic [1:0] m_mode [2];
  logic m_ssel [2], m_eta [2];
  logic [31:0] m_br [2];
  logic [9:0] m_bw [2];
  int m_to [2];
  int mc;
  bit mfound;

  initial begin
    m_to[0] = TO0;
    m_to[1] = TO1;
  end

  always @(posedge clk or negedge aresetn) begin
    for (int k = 0; k < 2; k++) begin
      if (!aresetn) begin
        m_st[k] = 0; m_own[k] = 0; m_ptr[k] = 0; m_run[k] = 0; m_tf[k] = 0;
        m_mode[k] = 0; m_ssel[k] = 0; m_eta[k] = 0; m_br[k] = 0; m_bw[k] = 0;
      end else begin
        case (m_st[k])
          0: if (!hold && req != 0) begin
               mfound = 0;
               for (int j = 0; j < N; j++) begin
                 mc = (m_ptr[k] + j) % N;
                 if (!mfound && req[mc]) begin
                   mfound = 1;
                   m_own[k] = mc;
                 end
               end
               m_mode[k] = req_mode[2*m_own[k] +: 2];
               m_ssel[k] = req_sample_sel[m_own[k]];
               m_eta[k]  = req_eta[m_own[k]];
               m_br[k]   = req_byte_read[32*m_own[k] +: 32];
               m_bw[k]   = req_byte_write[10*m_own[k] +: 10];
               m_st[k]   = 1;
             end
          1: m_st[k] = 2;
          2: begin m_st[k] = 3; m_run[k] = 0; end
          3: begin
               if (SHA3_done) begin
                 m_st[k] = 4; m_tf[k] = 0;
               end else begin
                 m_run[k] = m_run[k] + 1;
                 if (m_to[k] != 0 && m_run[k] == m_to[k]) begin
                   m_st[k] = 4; m_tf[k] = 1;
                 end
               end
             end
          4: begin m_st[k] = 5; m_ptr[k] = (m_own[k] + 1) % N; end
          default: m_st[k] = 0;
        endcase
      end
    end
  end

  logic [N-1:0] c_g, c_a, c_e;
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        c_g = (m_st[k] >= 1 && m_st[k] <= 4) ? N'(1 << m_own[k]) : '0;
        c_a = (m_st[k] == 4) ? c_g : '0;
        c_e = (m_st[k] == 4 && m_tf[k]) ? c_g : '0;
        chk($sformatf("grant[%0d]", k), grant_o[k], c_g);
        chk($sformatf("ack[%0d]", k), ack_o[k], c_a);
        chk($sformatf("err[%0d]", k), err_o[k], c_e);
        chk($sformatf("busy[%0d]", k), busy_o[k], m_st[k] != 0);
        chk($sformatf("start[%0d]", k), start_o[k], m_st[k] == 1);
        if (m_st[k] != 0) begin
          chk($sformatf("mode[%0d]", k), mode_o[k], m_mode[k]);
          chk($sformatf("ssel[%0d]", k), ssel_o[k], m_ssel[k]);
          chk($sformatf("eta[%0d]", k), eta_o[k], m_eta[k]);
          chk($sformatf("byte_read[%0d]", k), br_o[k], m_br[k]);
          chk($sformatf("byte_write[%0d]", k), bw_o[k], m_bw[k]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    aresetn = 1'b0; req = '0; SHA3_done = 1'b0; hold = 1'b0;
    tick(); tick();
    aresetn = 1'b1;
    tick();
  endtask

  task automatic wait_start(input int k);
    int n = 0;
    while (!start_o[k] && n < 12) begin
      tick();
      n++;
    end
    chk($sformatf("wait_start[%0d]", k), start_o[k], 1);
  endtask

  logic [N-1:0] rr_exp [5];

  initial begin
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;
    aresetn = 1'b0; hold = 1'b0; SHA3_done = 1'b0; req = '0;
    req_mode = '0; req_sample_sel = '0; req_eta = '0;
    req_byte_read = '0; req_byte_write = '0;
    do_reset();
    chk_en = 1'b1;
    chk("rst_grant", grant_o[0], 0);
    chk("rst_busy", busy_o[0], 0);
    chk("rst_start", start_o[0], 0);

    // single job
    req_mode[1:0] = 2'd2; req_byte_read[31:0] = 32'd32; req_byte_write[9:0] = 10'd136;
    req_sample_sel[0] = 1'b1;
    req = 4'b0001;
    tick();
    chk("s1_start", start_o[0], 1);
    chk("s1_grant", grant_o[0], 4'b0001);
    chk("s1_mode", mode_o[0], 2);
    chk("s1_br", br_o[0], 32);
    chk("s1_bw", bw_o[0], 136);
    repeat (20) tick();
    SHA3_done = 1'b1;
    tick();
    chk("s1_ack", ack_o[0], 4'b0001);
    chk("s1_err", err_o[0], 0);
    SHA3_done = 1'b0; req = '0;
    tick();
    chk("s1_grant_off", grant_o[0], 0);

    // round-robin with all requesters held
    do_reset();
    for (int i = 0; i < N; i++) begin
      req_mode[2*i +: 2] = 2'(i);
      req_byte_read[32*i +: 32] = 32'(100 + i);
      req_byte_write[10*i +: 10] = 10'(10 + i);
    end
    req_sample_sel = 4'b0101; req_eta = 4'b0011;
    req = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      wait_start(0);
      chk("rr_grant", grant_o[0], rr_exp[j]);
      chk("rr_br", br_o[0], 32'(100 + (j % 4)));
      repeat (3) tick();
      SHA3_done = 1'b1;
      tick();
      SHA3_done = 1'b0;
      chk("rr_ack", ack_o[0], rr_exp[j]);
    end

    // stale done level carried into the next job
    do_reset();
    req = 4'b0001;
    wait_start(0);
    repeat (3) tick();
    SHA3_done = 1'b1;
    tick();
    chk("st_ack0", ack_o[0], 4'b0001);
    req = 4'b0010;
    tick(); tick(); tick();
    chk("st_start", start_o[0], 1);
    chk("st_grant", grant_o[0], 4'b0010);
    tick();
    chk("st_guard_noack", ack_o[0], 0);
    tick();
    SHA3_done = 1'b0;
    chk("st_run_noack", ack_o[0], 0);
    tick(); tick();
    chk("st_run_noack2", ack_o[0], 0);
    SHA3_done = 1'b1;
    tick();
    chk("st_ack1", ack_o[0], 4'b0010);
    chk("st_err1", err_o[0], 0);
    SHA3_done = 1'b0; req = '0;

    // watchdog: dut1 times out after 8 run cycles, dut0 finishes on its terminal cycle
    do_reset();
    req = 4'b1100;
    wait_start(0);
    chk("to_grant1", grant_o[1], 4'b0100);
    tick(); tick();
    repeat (7) tick();
    chk("to_early", ack_o[1], 0);
    tick();
    chk("to_ack", ack_o[1], 4'b0100);
    chk("to_err", err_o[1], 4'b0100);
    req = 4'b1000;
    tick(); tick(); tick();
    chk("to_next_grant", grant_o[1], 4'b1000);
    chk("to_next_start", start_o[1], 1);
    repeat (10) tick();
    chk("to_ack2", ack_o[1], 4'b1000);
    chk("to_err2", err_o[1], 4'b1000);
    req = '0;
    tick(); tick();
    SHA3_done = 1'b1;
    tick();
    chk("tie_ack", ack_o[0], 4'b0100);
    chk("tie_err", err_o[0], 0);
    SHA3_done = 1'b0;

    // hold, then reset in the middle of a job
    do_reset();
    hold = 1'b1; req = 4'b0100;
    repeat (3) tick();
    chk("hold_grant", grant_o[0], 0);
    chk("hold_busy", busy_o[0], 0);
    hold = 1'b0;
    tick();
    chk("unhold_grant", grant_o[0], 4'b0100);
    tick(); tick(); tick();
    aresetn = 1'b0;
    #1;
    chk("arst_grant", grant_o[0], 0);
    chk("arst_busy", busy_o[0], 0);
    chk("arst_br", br_o[0], 0);
    chk("arst_mode", mode_o[0], 0);
    req = '0;
    tick(); tick();
    aresetn = 1'b1;
    repeat (3) tick();
    chk("arst_noack", ack_o[0], 0);

    // descriptor frozen while granted
    do_reset();
    req_byte_read[63:32] = 32'd64;
    req = 4'b0010;
    wait_start(0);
    chk("frz_br0", br_o[0], 64);
    tick(); tick();
    req_byte_read[63:32] = 32'd99;
    repeat (3) tick();
    chk("frz_br1", br_o[0], 64);
    SHA3_done = 1'b1;
    tick();
    chk("frz_ack", ack_o[0], 4'b0010);
    SHA3_done = 1'b0; req = '0;
    tick();
    chk("frz_br_rel", br_o[0], 64);
    chk("frz_grant_rel", grant_o[0], 0);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not reach the end");
    $fatal(1, "time limit");
  end

endmodule
